// File: rtl/pin_entry_collector_pkg.sv
// Shared definitions for the PIN entry path: state encoding, key codes, digit count.
package pin_entry_collector_pkg;

  localparam int unsigned PIN_NUM_DIGITS     = 4;
  localparam int unsigned PIN_TIMEOUT_CYCLES = 1000;
  localparam logic [3:0]  PIN_KEY_CLEAR      = 4'hA;
  localparam logic [3:0]  PIN_KEY_ENTER      = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2,
    ST_SUBMIT  = 2'd3
  } pin_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_entry_collector_idle_timer.sv
// Inactivity counter: clears on request, counts while enabled, flags the last idle cycle.
module pin_entry_collector_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned   CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count idle cycles, holding at the terminal value until cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign done = enable && (cnt == LAST);

endmodule

// File: rtl/pin_entry_collector.sv
// Keypad-to-PIN collector: shifts BCD digits MSB-first, issues enter/short/timeout pulses.
module pin_entry_collector
  import pin_entry_collector_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = PIN_NUM_DIGITS,
  parameter int unsigned TIMEOUT_CYCLES = PIN_TIMEOUT_CYCLES,
  parameter logic [3:0]  KEY_CLEAR      = PIN_KEY_CLEAR,
  parameter logic [3:0]  KEY_ENTER      = PIN_KEY_ENTER
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  output logic [4*NUM_DIGITS-1:0] inpin,
  output logic                    enter,
  output logic [2:0]              digit_count,
  output logic                    short_err,
  output logic                    timeout_err
);

  localparam int unsigned W          = 4 * NUM_DIGITS;
  localparam logic [2:0]  FULL_COUNT = 3'(NUM_DIGITS);

  pin_state_e     state, state_n;
  logic [W-1:0]   inpin_n;
  logic [2:0]     count_n;
  logic           enter_n, short_n, timeout_n;

  logic is_dig, is_clr, is_ent, key_act;
  logic tmr_en, tmr_clear, tmr_done;

  assign is_dig  = key_valid && is_digit(key_code);
  assign is_clr  = key_valid && (key_code == KEY_CLEAR);
  assign is_ent  = key_valid && (key_code == KEY_ENTER);
  assign key_act = is_dig || is_clr || is_ent;

  assign tmr_en    = (state == ST_COLLECT) || (state == ST_FULL);
  assign tmr_clear = !tmr_en || key_act;

  pin_entry_collector_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .reset (reset),
    .clear (tmr_clear),
    .enable(tmr_en),
    .done  (tmr_done)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      inpin       <= '0;
      digit_count <= '0;
      enter       <= 1'b0;
      short_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      inpin       <= inpin_n;
      digit_count <= count_n;
      enter       <= enter_n;
      short_err   <= short_n;
      timeout_err <= timeout_n;
    end
  end

  // Next-state selection; any accepted key takes priority over the timeout.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (is_dig) state_n = (FULL_COUNT == 3'd1) ? ST_FULL : ST_COLLECT;
      end
      ST_COLLECT: begin
        if (is_clr || is_ent) state_n = ST_IDLE;
        else if (is_dig)      state_n = ((digit_count + 3'd1) == FULL_COUNT) ? ST_FULL : ST_COLLECT;
        else if (tmr_done)    state_n = ST_IDLE;
      end
      ST_FULL: begin
        if (is_clr)                  state_n = ST_IDLE;
        else if (is_ent)             state_n = ST_SUBMIT;
        else if (tmr_done && !is_dig) state_n = ST_IDLE;
      end
      ST_SUBMIT: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Datapath and pulse values to register on the next edge.
  always_comb begin
    inpin_n   = inpin;
    count_n   = digit_count;
    enter_n   = 1'b0;
    short_n   = 1'b0;
    timeout_n = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (is_dig) begin
          inpin_n = W'(key_code);
          count_n = 3'd1;
        end else if (is_clr) begin
          inpin_n = '0;
        end else if (is_ent) begin
          short_n = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (is_dig) begin
          inpin_n = (inpin << 4) | W'(key_code);
          count_n = digit_count + 3'd1;
        end else if (is_clr) begin
          inpin_n = '0;
          count_n = '0;
        end else if (is_ent) begin
          short_n = 1'b1;
          inpin_n = '0;
          count_n = '0;
        end else if (tmr_done) begin
          timeout_n = 1'b1;
          inpin_n   = '0;
          count_n   = '0;
        end
      end
      ST_FULL: begin
        if (is_clr) begin
          inpin_n = '0;
          count_n = '0;
        end else if (is_ent) begin
          enter_n = 1'b1;
          count_n = '0;
        end else if (tmr_done && !is_dig) begin
          timeout_n = 1'b1;
          inpin_n   = '0;
          count_n   = '0;
        end
      end
      ST_SUBMIT: begin
        count_n = '0;
      end
      default: begin
        inpin_n = '0;
        count_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pin_entry_collector.sv
// Scoreboard bench for pin_entry_collector with a short inactivity timeout.
module tb_pin_entry_collector;

  localparam logic [15:0] SETPIN  = 16'h1234;
  localparam logic [2:0]  P_ENTER = 3'b100;
  localparam logic [2:0]  P_SHORT = 3'b010;
  localparam logic [2:0]  P_TMO   = 3'b001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] inpin;
  logic        enter;
  logic [2:0]  digit_count;
  logic        short_err;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0]  pulses;
    logic [15:0] pin;
  } exp_t;

  exp_t exp_q[$];
  exp_t got;

  pin_entry_collector #(
    .NUM_DIGITS    (4),
    .TIMEOUT_CYCLES(8),
    .KEY_CLEAR     (4'hA),
    .KEY_ENTER     (4'hB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .inpin      (inpin),
    .enter      (enter),
    .digit_count(digit_count),
    .short_err  (short_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Every pulse must match the oldest expected event, in kind and PIN value.
  always @(negedge clk) begin
    if (reset && (enter || short_err || timeout_err)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got pulses=%b inpin=%h, required no pulse",
                 {enter, short_err, timeout_err}, inpin);
      end else begin
        got = exp_q.pop_front();
        if ({enter, short_err, timeout_err, inpin} !== {got.pulses, got.pin}) begin
          miscompares++;
          $display("FAIL pulse_event: got pulses=%b inpin=%h, required pulses=%b inpin=%h",
                   {enter, short_err, timeout_err}, inpin, got.pulses, got.pin);
        end
      end
    end
  end

  task automatic press(input logic [3:0] c);
    key_code  = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic [2:0] p, input logic [15:0] pin);
    exp_q.push_back({p, pin});
  endtask

  task automatic drain(input string name);
    idle(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_pulse: got %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_timeout(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    idle(2);
    vectors++;
    if ({inpin, enter, digit_count, short_err, timeout_err} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0",
               {inpin, enter, digit_count, short_err, timeout_err});
    end
    reset = 1'b1;
    idle(1);
  endtask

  task automatic test_submit();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    vectors++;
    if ({inpin, digit_count} !== {16'h1234, 3'd4}) begin
      miscompares++;
      $display("FAIL submit_collect: got inpin=%h count=%0d, required 1234/4", inpin, digit_count);
    end
    expect_pulse(P_ENTER, 16'h1234);
    press(4'hB);
    vectors++;
    if ((enter && (inpin == SETPIN)) !== 1'b1) begin
      miscompares++;
      $display("FAIL submit_access: got enter=%b inpin=%h, required enter=1 inpin=%h", enter, inpin, SETPIN);
    end
    idle(1);
    vectors++;
    if ({enter, digit_count, inpin} !== {1'b0, 3'd0, 16'h1234}) begin
      miscompares++;
      $display("FAIL submit_after: got enter=%b count=%0d inpin=%h, required 0/0/1234", enter, digit_count, inpin);
    end
    drain("submit");
  endtask

  task automatic test_short();
    expect_pulse(P_SHORT, 16'h0000);
    press(4'h1); press(4'h2); press(4'hB);
    vectors++;
    if ({inpin, digit_count} !== 19'd0) begin
      miscompares++;
      $display("FAIL short_clears: got inpin=%h count=%0d, required 0/0", inpin, digit_count);
    end
    drain("short");
  endtask

  task automatic test_overflow();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    vectors++;
    if ({inpin, digit_count} !== {16'h1234, 3'd4}) begin
      miscompares++;
      $display("FAIL overflow_ignored: got inpin=%h count=%0d, required 1234/4", inpin, digit_count);
    end
    expect_pulse(P_ENTER, 16'h1234);
    press(4'hB);
    idle(1);
    drain("overflow");
  endtask

  task automatic test_clear();
    press(4'h9); press(4'h8);
    vectors++;
    if (inpin !== 16'h0098) begin
      miscompares++;
      $display("FAIL clear_partial: got inpin=%h, required 0098", inpin);
    end
    press(4'hA);
    vectors++;
    if ({inpin, digit_count} !== 19'd0) begin
      miscompares++;
      $display("FAIL clear_drops: got inpin=%h count=%0d, required 0/0", inpin, digit_count);
    end
    press(4'h5); press(4'h6); press(4'h7); press(4'h8);
    expect_pulse(P_ENTER, 16'h5678);
    press(4'hB);
    idle(1);
    drain("clear");
  endtask

  task automatic test_idle_keys();
    expect_pulse(P_SHORT, 16'h5678);
    press(4'hB);
    vectors++;
    if ({inpin, digit_count} !== {16'h5678, 3'd0}) begin
      miscompares++;
      $display("FAIL idle_enter_keeps_pin: got inpin=%h count=%0d, required 5678/0", inpin, digit_count);
    end
    press(4'hA);
    press(4'hD);
    vectors++;
    if ({inpin, digit_count} !== 19'd0) begin
      miscompares++;
      $display("FAIL idle_clear: got inpin=%h count=%0d, required 0/0", inpin, digit_count);
    end
    drain("idle_keys");
  endtask

  task automatic test_timeout();
    int cyc;
    expect_pulse(P_TMO, 16'h0000);
    press(4'h7);
    wait_timeout(cyc);
    vectors++;
    if (cyc != 8) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d cycles, required 8", cyc);
    end
    vectors++;
    if ({inpin, digit_count} !== 19'd0) begin
      miscompares++;
      $display("FAIL timeout_clears: got inpin=%h count=%0d, required 0/0", inpin, digit_count);
    end
    drain("timeout");

    expect_pulse(P_TMO, 16'h0000);
    press(4'h7);
    idle(6);
    press(4'h8);
    vectors++;
    if (inpin !== 16'h0078) begin
      miscompares++;
      $display("FAIL timeout_restart_pin: got inpin=%h, required 0078", inpin);
    end
    wait_timeout(cyc);
    vectors++;
    if (cyc != 8) begin
      miscompares++;
      $display("FAIL timeout_restart: got %0d cycles after second key, required 8", cyc);
    end
    drain("timeout_restart");

    press(4'h7);
    idle(7);
    press(4'h3);
    vectors++;
    if ({timeout_err, inpin, digit_count} !== {1'b0, 16'h0073, 3'd2}) begin
      miscompares++;
      $display("FAIL timeout_key_wins: got tmo=%b inpin=%h count=%0d, required 0/0073/2",
               timeout_err, inpin, digit_count);
    end
    press(4'hA);
    drain("timeout_key_wins");

    expect_pulse(P_TMO, 16'h0000);
    press(4'h7);
    idle(3);
    press(4'hC);
    wait_timeout(cyc);
    vectors++;
    if (cyc != 4) begin
      miscompares++;
      $display("FAIL timeout_ignored_code: got %0d cycles after ignored key, required 4", cyc);
    end
    drain("timeout_ignored");
  endtask

  task automatic test_reset_mid();
    press(4'h1); press(4'h2);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({inpin, enter, digit_count, short_err, timeout_err} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_async: got %h, required 0",
               {inpin, enter, digit_count, short_err, timeout_err});
    end
    @(negedge clk);
    reset = 1'b1;
    press(4'h5); press(4'h6); press(4'h7); press(4'h8);
    vectors++;
    if ({inpin, digit_count} !== {16'h5678, 3'd4}) begin
      miscompares++;
      $display("FAIL reset_fresh_entry: got inpin=%h count=%0d, required 5678/4", inpin, digit_count);
    end
    expect_pulse(P_ENTER, 16'h5678);
    press(4'hB);
    idle(1);
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_submit();
    test_short();
    test_overflow();
    test_clear();
    test_idle_keys();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

endmodule
